sparse_event_sched: RTL and testbench

- Sparsity-aware input scheduler in front of the neuron/MVM datapath.
- Buffers one input-current vector of N_LANES entries and, on start, streams only the non-zero entries, lowest index first, over a valid/ready handshake.
- Zero entries cost no datapath cycles.
- Signals end of timestep and keeps a wrapping timestep counter.

---
 rtl/sparse_event_sched_pkg.sv | 15 +
 rtl/sparse_event_sched_lsb_prio_enc.sv | 21 ++
 rtl/sparse_event_sched.sv | 113 +++++++++++
 tb/tb_sparse_event_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_event_sched_pkg.sv
// Shared types and defaults for the sparse event scheduler.
// FSM encoding plus default geometry constants.
package sparse_sched_pkg;

  localparam int DEF_N_LANES = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TS_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } sched_state_t;

endpackage

// File: rtl/sparse_event_sched_lsb_prio_enc.sv
// Lowest-set-bit priority encoder.
// Combinational; idx is 0 when no bit is set.
module lsb_prio_enc #(
  parameter  int N_LANES = 8,
  localparam int IDX_W   = $clog2(N_LANES)
) (
  input  logic [N_LANES-1:0] vec,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    idx = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/sparse_event_sched.sv
// Sparsity-aware input scheduler: buffers one vector and
// streams only its non-zero lanes, lowest index first.
module sparse_event_sched
  import sparse_sched_pkg::*;
#(
  parameter  int N_LANES = DEF_N_LANES,
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int TS_W    = DEF_TS_W,
  localparam int IDX_W   = $clog2(N_LANES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  input  logic              start,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W:0]    nz_count,
  output logic              done,
  output logic [TS_W-1:0]   timestep
);

  sched_state_t state_q, state_d;

  logic [N_LANES-1:0][DATA_W-1:0] buf_q, buf_d;
  logic [N_LANES-1:0] mask_q, mask_d;
  logic [N_LANES-1:0] pend_q, pend_clr, enc_in;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_any;
  logic [IDX_W:0]     pop;
  logic               wr_ok, accept, kick;

  assign busy      = (state_q == ISSUE);
  assign out_valid = (state_q == ISSUE);
  assign done      = (state_q == DONE);
  assign wr_ok     = wr_en && !busy;
  assign accept    = busy && out_ready;
  assign kick      = (state_q == IDLE) && start;

  // Same-cycle write is folded in so a start snapshots it.
  always_comb begin
    buf_d  = buf_q;
    mask_d = mask_q;
    if (wr_ok) begin
      buf_d[wr_addr]  = wr_data;
      mask_d[wr_addr] = (wr_data != '0);
    end
    pend_clr          = pend_q;
    pend_clr[out_idx] = 1'b0;
    enc_in            = busy ? pend_clr : mask_d;
    pop               = '0;
    for (int i = 0; i < N_LANES; i++) begin
      pop = pop + {{IDX_W{1'b0}}, mask_d[i]};
    end
  end

  lsb_prio_enc #(
    .N_LANES(N_LANES)
  ) u_enc (
    .vec(enc_in),
    .idx(enc_idx),
    .any(enc_any)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = (mask_d != '0) ? ISSUE : DONE;
      end
      ISSUE: begin
        if (out_ready && !enc_any) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      mask_q   <= '0;
      pend_q   <= '0;
      out_idx  <= '0;
      out_data <= '0;
      nz_count <= '0;
      timestep <= '0;
      wr_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      mask_q  <= mask_d;
      wr_err  <= wr_en && busy;
      if (kick) begin
        pend_q   <= mask_d;
        nz_count <= pop;
      end
      if (accept) pend_q <= pend_clr;
      if ((kick || accept) && enc_any) begin
        out_idx  <= enc_idx;
        out_data <= buf_d[enc_idx];
      end
      if (state_q == DONE) timestep <= timestep + 1'b1;
    end
  end

endmodule

// File: tb/tb_sparse_event_sched.sv
// Scoreboard bench for sparse_event_sched: expected lane
// issues are queued at start and popped as the DUT issues.
module tb_sparse_event_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_err;
  logic       start;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic [7:0] out_data;
  logic [3:0] nz_count;
  logic       done;
  logic [7:0] timestep;

  sparse_event_sched dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_err(wr_err),
    .start(start),
    .busy(busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx(out_idx),
    .out_data(out_data),
    .nz_count(nz_count),
    .done(done),
    .timestep(timestep)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_iss = 0;
  int   n_stall = 0;
  int   n_done = 0;
  int   n_busy = 0;
  int   done_cyc = 0;
  int   iss_cyc[8192];
  logic [7:0] exp_ts = 8'd0;

  localparam logic [63:0] VEC1 =
    {8'h03, 8'h00, 8'h00, 8'h09, 8'h00, 8'h00, 8'h05, 8'h00};
  localparam logic [63:0] VEC0 = 64'd0;
  localparam logic [63:0] VECF =
    {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected issue", 32'(out_idx), 32'hFFFF);
        end else begin
          check("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
          check("out_data", 32'(out_data), 32'(exp_q[0].data));
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (n_iss < 8192) iss_cyc[n_iss] = cyc;
            n_iss++;
          end else begin
            n_stall++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load(input logic [63:0] v);
    for (int i = 0; i < 8; i++) wr(i, v[8*i +: 8]);
  endtask

  task automatic push_vec(input logic [63:0] v);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      if (v[8*i +: 8] != 8'd0) begin
        e.idx  = 3'(i);
        e.data = v[8*i +: 8];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic kick(output int t0, output int d0);
    d0    = n_done;
    t0    = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int limit);
    for (int n = 0; n < limit && n_done == d0; n++) tick();
    if (n_done == d0) check("done timeout", 0, 1);
    exp_ts++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, d0, i0, b0, s0;
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("rst out_valid", 32'(out_valid), 0);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst wr_err", 32'(wr_err), 0);
    check("rst nz_count", 32'(nz_count), 0);
    check("rst timestep", 32'(timestep), 0);
    rst = 1'b0;
    tick();

    // sparse vector, ready tied high
    load(VEC1);
    check("no wr_err idle", 32'(wr_err), 0);
    push_vec(VEC1);
    i0 = n_iss;
    kick(t0, d0);
    wait_done(d0, 20);
    check("t1 issues", 32'(n_iss - i0), 3);
    check("t1 first", 32'(iss_cyc[i0]), 32'(t0 + 1));
    check("t1 last", 32'(iss_cyc[n_iss-1]), 32'(t0 + 3));
    check("t1 done cyc", 32'(done_cyc), 32'(t0 + 4));
    check("t1 nz_count", 32'(nz_count), 3);
    check("t1 timestep", 32'(timestep), 32'(exp_ts));
    check("t1 busy low", 32'(busy), 0);

    // all-zero vector
    load(VEC0);
    i0 = n_iss;
    b0 = n_busy;
    kick(t0, d0);
    wait_done(d0, 20);
    check("t2 issues", 32'(n_iss - i0), 0);
    check("t2 busy", 32'(n_busy - b0), 0);
    check("t2 done cyc", 32'(done_cyc), 32'(t0 + 1));
    check("t2 nz_count", 32'(nz_count), 0);
    check("t2 timestep", 32'(timestep), 32'(exp_ts));

    // backpressure 1,0,0,1,1
    load(VEC1);
    push_vec(VEC1);
    i0 = n_iss;
    s0 = n_stall;
    kick(t0, d0);
    out_ready = 1'b1; tick();
    out_ready = 1'b0; tick();
    tick();
    out_ready = 1'b1;
    wait_done(d0, 20);
    check("t3 issues", 32'(n_iss - i0), 3);
    check("t3 stalls", 32'(n_stall - s0), 2);
    check("t3 last", 32'(iss_cyc[n_iss-1]), 32'(t0 + 5));
    check("t3 done cyc", 32'(done_cyc), 32'(iss_cyc[n_iss-1] + 1));
    check("t3 timestep", 32'(timestep), 32'(exp_ts));

    // write and start while busy
    push_vec(VEC1);
    out_ready = 1'b0;
    i0 = n_iss;
    kick(t0, d0);
    check("t4 busy", 32'(busy), 1);
    wr(2, 8'h77);
    check("t4 wr_err pulse", 32'(wr_err), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4 wr_err clear", 32'(wr_err), 0);
    out_ready = 1'b1;
    wait_done(d0, 20);
    repeat (4) tick();
    check("t4 one done", 32'(n_done - d0), 1);
    check("t4 issues", 32'(n_iss - i0), 3);
    push_vec(VEC1);
    kick(t0, d0);
    wait_done(d0, 20);
    check("t4 lane2 kept", 32'(nz_count), 3);
    check("t4 timestep", 32'(timestep), 32'(exp_ts));

    // dense vector and timestep wrap
    load(VECF);
    while (exp_ts != 8'hFF) begin
      push_vec(VECF);
      kick(t0, d0);
      wait_done(d0, 20);
    end
    check("pre-wrap ts", 32'(timestep), 32'hFF);
    push_vec(VECF);
    i0 = n_iss;
    kick(t0, d0);
    wait_done(d0, 20);
    check("t5 issues", 32'(n_iss - i0), 8);
    check("t5 first", 32'(iss_cyc[i0]), 32'(t0 + 1));
    check("t5 last", 32'(iss_cyc[n_iss-1]), 32'(t0 + 8));
    check("t5 done cyc", 32'(done_cyc), 32'(t0 + 9));
    check("t5 nz_count", 32'(nz_count), 8);
    check("t5 wrap", 32'(timestep), 0);

    // reset during issue
    load(VEC1);
    exp_q.push_back('{idx: 3'd1, data: 8'h05});
    kick(t0, d0);
    tick();
    rst = 1'b1;
    tick();
    check("t6 out_valid", 32'(out_valid), 0);
    check("t6 busy", 32'(busy), 0);
    check("t6 done", 32'(done), 0);
    check("t6 wr_err", 32'(wr_err), 0);
    check("t6 out_idx", 32'(out_idx), 0);
    check("t6 out_data", 32'(out_data), 0);
    check("t6 nz_count", 32'(nz_count), 0);
    check("t6 timestep", 32'(timestep), 0);
    check("t6 queue", 32'(exp_q.size()), 0);
    rst = 1'b0;
    exp_ts = 8'd0;
    repeat (3) tick();
    check("t6 no done", 32'(n_done - d0), 0);
    i0 = n_iss;
    kick(t0, d0);
    wait_done(d0, 20);
    check("t6 issues", 32'(n_iss - i0), 0);
    check("t6 done cyc", 32'(done_cyc), 32'(t0 + 1));
    check("t6 ts after", 32'(timestep), 32'(exp_ts));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
